// File: rtl/secuenciador_escritura_rtc.sv
// Write sequencer for a multiplexed-bus RTC: walks the time/date (and optionally timer)
// registers, emitting address and data strobe phases. Macro TIMER_ESCRITURA_EN adds timer registers 7..9.
module secuenciador_escritura_rtc #(
  parameter int T_FASE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] dato_in,
  output logic [3:0] sel_reg,
  output logic [7:0] ad_bus,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [2:0] {
    IDLE, ADR_LOW, ADR_HIGH, DAT_LOW, DAT_HIGH, FIN
  } estado_t;

`ifdef TIMER_ESCRITURA_EN
  localparam logic [3:0] ULTIMO = 4'd9;
`else
  localparam logic [3:0] ULTIMO = 4'd6;
`endif
  localparam logic [3:0] FASE_FIN = 4'(T_FASE - 1);

  estado_t    estado, estado_sig;
  logic [3:0] fase_cnt, fase_cnt_sig;
  logic [3:0] indice, indice_sig;
  logic [7:0] dato_lat, dato_lat_sig;
  logic       fase_fin;

  assign fase_fin = (fase_cnt == FASE_FIN);

  function automatic logic [7:0] dir_rtc(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h27;
      4'd7:    return 8'h41;
      4'd8:    return 8'h42;
      4'd9:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= IDLE;
      fase_cnt <= 4'd0;
      indice   <= 4'd0;
      dato_lat <= 8'h00;
    end else begin
      estado   <= estado_sig;
      fase_cnt <= fase_cnt_sig;
      indice   <= indice_sig;
      dato_lat <= dato_lat_sig;
    end
  end

  // Every bus phase lasts exactly T_FASE cycles; the data byte is captured
  // on the edge that leaves ADR_HIGH so it stays stable for both data phases.
  always_comb begin
    estado_sig   = estado;
    fase_cnt_sig = fase_cnt;
    indice_sig   = indice;
    dato_lat_sig = dato_lat;
    case (estado)
      IDLE: begin
        fase_cnt_sig = 4'd0;
        if (iniciar) begin
          estado_sig = ADR_LOW;
          indice_sig = 4'd0;
        end
      end
      ADR_LOW, ADR_HIGH, DAT_LOW, DAT_HIGH: begin
        if (!fase_fin) begin
          fase_cnt_sig = fase_cnt + 4'd1;
        end else begin
          fase_cnt_sig = 4'd0;
          if (estado == ADR_LOW) begin
            estado_sig = ADR_HIGH;
          end else if (estado == ADR_HIGH) begin
            estado_sig   = DAT_LOW;
            dato_lat_sig = dato_in;
          end else if (estado == DAT_LOW) begin
            estado_sig = DAT_HIGH;
          end else if (indice == ULTIMO) begin
            estado_sig = FIN;
          end else begin
            estado_sig = ADR_LOW;
            indice_sig = indice + 4'd1;
          end
        end
      end
      FIN: begin
        estado_sig   = IDLE;
        indice_sig   = 4'd0;
        fase_cnt_sig = 4'd0;
      end
      default: begin
        estado_sig   = IDLE;
        indice_sig   = 4'd0;
        fase_cnt_sig = 4'd0;
      end
    endcase
  end

  always_comb begin
    sel_reg = (estado == IDLE) ? 4'd0 : indice;
    ad_bus  = 8'h00;
    ad_oe   = 1'b0;
    a_d     = 1'b0;
    cs_n    = 1'b1;
    wr_n    = 1'b1;
    rd_n    = 1'b1;
    ocupado = 1'b0;
    listo   = 1'b0;
    case (estado)
      ADR_LOW: begin
        ad_bus = dir_rtc(indice); ad_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0; ocupado = 1'b1;
      end
      ADR_HIGH: begin
        ad_bus = dir_rtc(indice); ad_oe = 1'b1; ocupado = 1'b1;
      end
      DAT_LOW: begin
        ad_bus = dato_lat; ad_oe = 1'b1; a_d = 1'b1; cs_n = 1'b0; wr_n = 1'b0; ocupado = 1'b1;
      end
      DAT_HIGH: begin
        ad_bus = dato_lat; ad_oe = 1'b1; a_d = 1'b1; ocupado = 1'b1;
      end
      FIN: begin
        ocupado = 1'b1;
        listo   = 1'b1;
      end
      default: begin
        sel_reg = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_secuenciador_escritura_rtc.sv
// Bench for secuenciador_escritura_rtc: two instances (T_FASE=4 and T_FASE=1) checked cycle by
// cycle against a phase-arithmetic model of the write sequence.
module tb_secuenciador_escritura_rtc;

`ifdef TIMER_ESCRITURA_EN
  localparam int N_REG = 10;
`else
  localparam int N_REG = 7;
`endif
  localparam logic [18:0] IDLE_V = {4'd0, 8'h00, 7'b0011100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       iniciar0, iniciar1;
  logic [7:0] dato_in0, dato_in1;
  logic [3:0] sel_reg0, sel_reg1;
  logic [7:0] ad_bus0, ad_bus1;
  logic       ad_oe0, a_d0, cs_n0, wr_n0, rd_n0, ocupado0, listo0;
  logic       ad_oe1, a_d1, cs_n1, wr_n1, rd_n1, ocupado1, listo1;
  logic [18:0] obs0, obs1;

  logic [7:0] dat_val [16];
  logic       use_noise;
  logic [7:0] noise;
  int         errors = 0;
  int         checks = 0;

  assign dato_in0 = use_noise ? noise : dat_val[sel_reg0];
  assign dato_in1 = dat_val[sel_reg1];
  assign obs0 = {sel_reg0, ad_bus0, ad_oe0, a_d0, cs_n0, wr_n0, rd_n0, ocupado0, listo0};
  assign obs1 = {sel_reg1, ad_bus1, ad_oe1, a_d1, cs_n1, wr_n1, rd_n1, ocupado1, listo1};

  secuenciador_escritura_rtc #(.T_FASE(4)) u_dut0 (
    .clk(clk), .reset(reset), .iniciar(iniciar0), .dato_in(dato_in0),
    .sel_reg(sel_reg0), .ad_bus(ad_bus0), .ad_oe(ad_oe0), .a_d(a_d0),
    .cs_n(cs_n0), .wr_n(wr_n0), .rd_n(rd_n0), .ocupado(ocupado0), .listo(listo0)
  );

  secuenciador_escritura_rtc #(.T_FASE(1)) u_dut1 (
    .clk(clk), .reset(reset), .iniciar(iniciar1), .dato_in(dato_in1),
    .sel_reg(sel_reg1), .ad_bus(ad_bus1), .ad_oe(ad_oe1), .a_d(a_d1),
    .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1), .ocupado(ocupado1), .listo(listo1)
  );

  // Expected outputs for cycle c after the accepting edge (c=1 is the first
  // address cycle); the sequence is N_REG registers x 4 phases x t cycles, then FIN.
  function automatic logic [18:0] expect_out(input int c, input int t);
    int total = 4 * N_REG * t + 1;
    int i, ph;
    logic [7:0] addr;
    if (c < 1 || c > total) return IDLE_V;
    if (c == total) return {4'(N_REG - 1), 8'h00, 7'b0011111};
    i  = (c - 1) / (4 * t);
    ph = ((c - 1) / t) % 4;
    addr = (i < 7) ? 8'(8'h21 + i) : 8'(8'h41 + i - 7);
    case (ph)
      0:       return {4'(i), addr, 7'b1000110};
      1:       return {4'(i), addr, 7'b1011110};
      2:       return {4'(i), dat_val[i], 7'b1100110};
      default: return {4'(i), dat_val[i], 7'b1111110};
    endcase
  endfunction

  task automatic load_data(input bit fixed);
    for (int i = 0; i < 16; i++)
      dat_val[i] = fixed ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
  endtask

  task automatic run_seq(input int inst, input int pulse_at, input bit noisy,
                         input bit fixed, input string name);
    int t, total, listo_n, ocup_n, cs_fall, ph;
    logic prev_cs;
    logic [18:0] obs, exp_v;
    t = (inst != 0) ? 1 : 4;
    total = 4 * N_REG * t + 1;
    listo_n = 0; ocup_n = 0; cs_fall = 0; prev_cs = 1'b1;
    load_data(fixed);
    @(negedge clk);
    if (inst != 0) iniciar1 = 1'b1; else iniciar0 = 1'b1;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin iniciar0 = 1'b0; iniciar1 = 1'b0; end
      if (pulse_at > 0 && c == pulse_at) iniciar0 = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) iniciar0 = 1'b0;
      obs = (inst != 0) ? obs1 : obs0;
      exp_v = expect_out(c, t);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_v);
      end
      if (obs[1]) ocup_n++;
      if (obs[0]) listo_n++;
      if (prev_cs && !obs[4]) cs_fall++;
      prev_cs = obs[4];
      ph = ((c - 1) / t) % 4;
      use_noise = noisy && (c < total) && (ph >= 2);
      noise = 8'($urandom_range(0, 255));
    end
    use_noise = 1'b0;
    checks++;
    if (listo_n != 1) begin
      errors++; $display("FAIL %s listo_count: got %0d expected 1", name, listo_n);
    end
    checks++;
    if (ocup_n != total) begin
      errors++; $display("FAIL %s ocupado_cycles: got %0d expected %0d", name, ocup_n, total);
    end
    checks++;
    if (cs_fall != 2 * N_REG) begin
      errors++; $display("FAIL %s cs_strobes: got %0d expected %0d", name, cs_fall, 2 * N_REG);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar0 = 1'b1; iniciar1 = 1'b0; use_noise = 1'b0; noise = 8'h00;
    load_data(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs0 !== IDLE_V || obs1 !== IDLE_V) begin
      errors++; $display("FAIL reset_state: got %h/%h expected %h", obs0, obs1, IDLE_V);
    end
    iniciar0 = 1'b0;
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (obs0 !== IDLE_V || obs1 !== IDLE_V) begin
        errors++; $display("FAIL idle_after_reset: got %h/%h expected %h", obs0, obs1, IDLE_V);
      end
    end
  endtask

  task automatic test_full_sequence();
    run_seq(0, 0, 1'b0, 1'b1, "full_seq");
  endtask

  task automatic test_random_data();
    repeat (3) run_seq(0, 0, 1'b0, 1'b0, "random_data");
  endtask

  task automatic test_t_fase_1();
    run_seq(1, 0, 1'b0, 1'b0, "t_fase_1");
  endtask

  task automatic test_ignore_iniciar();
    run_seq(0, 50, 1'b0, 1'b0, "ignore_iniciar");
  endtask

  task automatic test_data_hold();
    run_seq(0, 0, 1'b1, 1'b0, "data_hold");
  endtask

  task automatic test_hold_through_fin();
    int total;
    logic [18:0] exp_v;
    total = 4 * N_REG * 4 + 1;
    load_data(1'b0);
    @(negedge clk);
    iniciar0 = 1'b1;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      exp_v = (c == total + 2) ? expect_out(1, 4) : expect_out(c, 4);
      checks++;
      if (obs0 !== exp_v) begin
        errors++;
        $display("FAIL hold_through_fin cycle %0d: got %h expected %h", c, obs0, exp_v);
      end
    end
    iniciar0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_abort();
    int cs_low;
    logic [18:0] exp_v;
    cs_low = 0;
    load_data(1'b0);
    @(negedge clk);
    iniciar0 = 1'b1;
    for (int c = 1; c < 58; c++) begin
      @(negedge clk);
      if (c == 1) iniciar0 = 1'b0;
      exp_v = expect_out(c, 4);
      checks++;
      if (obs0 !== exp_v) begin
        errors++;
        $display("FAIL abort_prefix cycle %0d: got %h expected %h", c, obs0, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs0 !== IDLE_V) begin
      errors++; $display("FAIL abort_immediate: got %h expected %h", obs0, IDLE_V);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (!cs_n0 || !wr_n0 || ocupado0 || listo0) cs_low++;
    end
    checks++;
    if (cs_low != 0 || obs0 !== IDLE_V) begin
      errors++;
      $display("FAIL abort_no_resume: got %0d active cycles, final %h expected 0, %h",
               cs_low, obs0, IDLE_V);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_random_data();
    test_t_fase_1();
    test_ignore_iniciar();
    test_data_hold();
    test_hold_through_fin();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
